// File: rtl/noc_pkg.sv
// Shared NoC link definitions: nibble/flit sizing and the serializer state type.
package noc_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned PACKET_W = 24;

  typedef logic [NIBBLE_W-1:0] flit_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } serializer_state_t;

endpackage

// File: rtl/nibble_shift_reg.sv
// Parallel-load register that shifts left one nibble at a time.
// Exposes the current top nibble and the nibble that becomes top after a shift.
module nibble_shift_reg
  import noc_pkg::*;
#(
  parameter int unsigned NIBBLES = 6
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        load_i,
  input  logic                        shift_i,
  input  logic [NIBBLE_W*NIBBLES-1:0] data_i,
  output flit_t                       top_o,
  output flit_t                       next_o
);

  localparam int unsigned W = NIBBLE_W * NIBBLES;

  logic [W-1:0] sreg_q;

  // Load has priority over shift; zeros enter from the bottom.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg_q <= '0;
    end else if (load_i) begin
      sreg_q <= data_i;
    end else if (shift_i) begin
      sreg_q <= {sreg_q[W-NIBBLE_W-1:0], {NIBBLE_W{1'b0}}};
    end
  end

  assign top_o  = sreg_q[W-1 -: NIBBLE_W];
  assign next_o = sreg_q[W-NIBBLE_W-1 -: NIBBLE_W];

endmodule

// File: rtl/packet_nibble_serializer.sv
// Serializes one 4*NIBBLES-bit packet into 4-bit link flits, MSB nibble first,
// with an optional trailing XOR checksum flit and an enforced idle gap.
module packet_nibble_serializer
  import noc_pkg::*;
#(
  parameter int unsigned NIBBLES     = 6,
  parameter int unsigned CHECKSUM_EN = 1,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input  logic                   clock,
  input  logic                   clear_n,
  input  logic                   pkt_valid,
  output logic                   pkt_ready,
  input  logic [4*NIBBLES-1:0]   packet_in,
  output logic                   link_valid,
  input  logic                   link_ready,
  output logic [3:0]             link_data,
  output logic                   link_sop,
  output logic                   link_eop,
  output logic                   busy
);

  localparam int unsigned FW = $clog2(NIBBLES + 2);
  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [FW-1:0] FLIT_LAST = FW'(NIBBLES - 1 + CHECKSUM_EN);
  localparam logic [FW-1:0] FLIT_CSUM = FW'(NIBBLES);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  serializer_state_t state_q, state_d;
  logic [FW-1:0]     flit_cnt_q, flit_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  flit_t             csum_q, csum_d;

  logic              pkt_ready_q, pkt_ready_d;
  logic              link_valid_q, link_valid_d;
  flit_t             link_data_q, link_data_d;
  logic              link_sop_q, link_sop_d;
  logic              link_eop_q, link_eop_d;
  logic              busy_q, busy_d;

  logic              load, shift, xfer;
  flit_t             top_nib, next_nib, nxt_top;

  nibble_shift_reg #(
    .NIBBLES (NIBBLES)
  ) u_sreg (
    .clk_i   (clock),
    .rst_ni  (clear_n),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (packet_in),
    .top_o   (top_nib),
    .next_o  (next_nib)
  );

  assign xfer = link_valid_q & link_ready;

  // Next state, counters, checksum, and the values the output registers take next.
  // Outputs are registered, so they are derived from the next-cycle view:
  // the nibble that will be on top after this cycle's load/shift, and the
  // checksum including any nibble transferring this cycle.
  always_comb begin
    state_d    = state_q;
    flit_cnt_d = flit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    csum_d     = csum_q;
    load       = 1'b0;
    shift      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pkt_valid && pkt_ready_q) begin
          load       = 1'b1;
          csum_d     = '0;
          flit_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (flit_cnt_q < FLIT_CSUM) begin
            shift  = 1'b1;
            csum_d = csum_q ^ top_nib;
          end
          if (flit_cnt_q == FLIT_LAST) begin
            flit_cnt_d = '0;
            gap_cnt_d  = '0;
            state_d    = (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            flit_cnt_d = flit_cnt_q + FW'(1);
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    nxt_top = load ? packet_in[4*NIBBLES-1 -: 4] : (shift ? next_nib : top_nib);

    link_valid_d = (state_d == SEND);
    link_data_d  = '0;
    if (state_d == SEND) begin
      link_data_d = ((CHECKSUM_EN != 0) && (flit_cnt_d == FLIT_CSUM)) ? csum_d : nxt_top;
    end
    link_sop_d  = (state_d == SEND) && (flit_cnt_d == '0);
    link_eop_d  = (state_d == SEND) && (flit_cnt_d == FLIT_LAST);
    busy_d      = (state_d != IDLE);
    pkt_ready_d = (state_d == IDLE);
  end

  // FSM state, counters, checksum and registered outputs.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= IDLE;
      flit_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      csum_q       <= '0;
      pkt_ready_q  <= 1'b0;
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
      link_sop_q   <= 1'b0;
      link_eop_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      flit_cnt_q   <= flit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      csum_q       <= csum_d;
      pkt_ready_q  <= pkt_ready_d;
      link_valid_q <= link_valid_d;
      link_data_q  <= link_data_d;
      link_sop_q   <= link_sop_d;
      link_eop_q   <= link_eop_d;
      busy_q       <= busy_d;
    end
  end

  assign pkt_ready  = pkt_ready_q;
  assign link_valid = link_valid_q;
  assign link_data  = link_data_q;
  assign link_sop   = link_sop_q;
  assign link_eop   = link_eop_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_packet_nibble_serializer.sv
// Bench for packet_nibble_serializer: default build (checksum, 1 gap cycle) and a
// CHECKSUM_EN=0 / GAP_CYCLES=0 build share the same stimulus, each tracked by its
// own packet-level reference model.
module tb_packet_nibble_serializer;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        pkt_valid;
  logic        link_ready;
  logic [23:0] packet_in;

  logic [1:0]       rdy, lv, sop, eop, bsy;
  logic [1:0][3:0]  ld;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clock = ~clock;

  packet_nibble_serializer #(
    .NIBBLES     (6),
    .CHECKSUM_EN (1),
    .GAP_CYCLES  (1)
  ) dut0 (
    .clock      (clock),
    .clear_n    (clear_n),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (rdy[0]),
    .packet_in  (packet_in),
    .link_valid (lv[0]),
    .link_ready (link_ready),
    .link_data  (ld[0]),
    .link_sop   (sop[0]),
    .link_eop   (eop[0]),
    .busy       (bsy[0])
  );

  packet_nibble_serializer #(
    .NIBBLES     (6),
    .CHECKSUM_EN (0),
    .GAP_CYCLES  (0)
  ) dut1 (
    .clock      (clock),
    .clear_n    (clear_n),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (rdy[1]),
    .packet_in  (packet_in),
    .link_valid (lv[1]),
    .link_ready (link_ready),
    .link_data  (ld[1]),
    .link_sop   (sop[1]),
    .link_eop   (eop[1]),
    .busy       (bsy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_seq(input string tag, input logic [3:0] got[$], input logic [3:0] exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [23:0] p);
    pkt_valid = 1'b1;
    packet_in = p;
    step(1);
    pkt_valid = 1'b0;
    packet_in = 24'h000000;
  endtask

  // Packet-level reference: a list of flits per accepted packet, a gap budget
  // after each packet, and readiness one edge after reset release.
  bit         m_active [2];
  bit         m_arm    [2];
  int         m_idx    [2];
  int         m_n      [2];
  int         m_gap    [2];
  logic [3:0] m_flits  [2][8];
  logic [3:0] obs0[$];
  logic [3:0] obs1[$];

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (!clear_n) begin
        check($sformatf("d%0d_reset_outs", d), {lv[d], sop[d], eop[d], bsy[d], rdy[d], ld[d]}, '0);
        m_active[d] = 1'b0;
        m_gap[d]    = 0;
        m_arm[d]    = 1'b0;
      end else begin
        check($sformatf("d%0d_valid", d), lv[d], m_active[d]);
        check($sformatf("d%0d_busy", d), bsy[d], m_active[d] || (m_gap[d] > 0));
        check($sformatf("d%0d_ready", d), rdy[d], m_arm[d] && !m_active[d] && (m_gap[d] == 0));
        if (m_active[d]) begin
          check($sformatf("d%0d_data", d), ld[d], m_flits[d][m_idx[d]]);
          check($sformatf("d%0d_sop", d), sop[d], m_idx[d] == 0);
          check($sformatf("d%0d_eop", d), eop[d], m_idx[d] == m_n[d] - 1);
          if (link_ready) begin
            if (d == 0) obs0.push_back(ld[0]);
            else        obs1.push_back(ld[1]);
            m_idx[d]++;
            if (m_idx[d] == m_n[d]) begin
              m_active[d] = 1'b0;
              m_gap[d]    = (d == 0) ? 1 : 0;
            end
          end
        end else if (m_gap[d] > 0) begin
          m_gap[d]--;
        end else if (m_arm[d] && pkt_valid) begin
          logic [3:0] cs;
          cs = 4'h0;
          for (int i = 0; i < 6; i++) begin
            m_flits[d][i] = packet_in[23-4*i -: 4];
            cs = cs ^ m_flits[d][i];
          end
          m_flits[d][6] = cs;
          m_n[d]        = (d == 0) ? 7 : 6;
          m_idx[d]      = 0;
          m_active[d]   = 1'b1;
        end
        m_arm[d] = 1'b1;
      end
    end
  end

  logic [3:0] exp_q[$];
  bit         hit;

  initial begin
    clear_n    = 1'b0;
    pkt_valid  = 1'b0;
    link_ready = 1'b1;
    packet_in  = 24'h000000;
    step(3);
    clear_n = 1'b1;
    step(2);

    // Basic packet on a free link.
    obs0.delete(); obs1.delete();
    send(24'hA5C3F1);
    step(12);
    exp_q = '{4'hA, 4'h5, 4'hC, 4'h3, 4'hF, 4'h1, 4'hE};
    check_seq("basic", obs0, exp_q);
    exp_q = '{4'hA, 4'h5, 4'hC, 4'h3, 4'hF, 4'h1};
    check_seq("basic_nocsum", obs1, exp_q);

    // Backpressure while flit C is presented.
    obs0.delete(); obs1.delete();
    send(24'hA5C3F1);
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!hit && lv[0] && ld[0] == 4'hC) begin
        hit = 1'b1;
        link_ready = 1'b0;
        step(3);
        link_ready = 1'b1;
      end
      step(1);
    end
    check("bp_flit_c_seen", hit, 1);
    exp_q = '{4'hA, 4'h5, 4'hC, 4'h3, 4'hF, 4'h1, 4'hE};
    check_seq("backpressure", obs0, exp_q);

    // Back-to-back with pkt_valid held high.
    obs0.delete(); obs1.delete();
    pkt_valid = 1'b1;
    packet_in = 24'h000000;
    step(1);
    packet_in = 24'hFFFFFF;
    step(9);
    pkt_valid = 1'b0;
    step(12);
    exp_q = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
              4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
    check_seq("b2b", obs0, exp_q);

    // Reset after the third flit transfers, then a fresh packet.
    obs0.delete(); obs1.delete();
    send(24'hABCDEF);
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      #1;
      if (obs0.size() >= 3) break;
    end
    check("rst_wait_3flits", obs0.size() >= 3, 1);
    @(posedge clock);
    #1;
    clear_n = 1'b0;
    obs0.delete(); obs1.delete();
    step(2);
    clear_n = 1'b1;
    step(2);
    send(24'h123456);
    step(12);
    exp_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
    check_seq("after_reset", obs0, exp_q);

    // Randomized traffic, including packet_in churn during SEND/GAP.
    for (int k = 0; k < 400; k++) begin
      pkt_valid  = 1'($urandom_range(0, 1));
      packet_in  = 24'($urandom);
      link_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    pkt_valid  = 1'b0;
    link_ready = 1'b1;
    step(20);
    check("drain_idle", {lv, bsy}, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
